wbs_regbank: RTL
================

# wbs_regbank

Wishbone slave register bank: the responder on one of the `wbs_*` ports that the Wishbone arbiter fans out. It decodes the shared address, answers reads and byte-lane writes to a block of 32-bit control registers, and signals bad accesses with `err`. It supports programmable wait states and an optional interrupt status/mask pair that drives the slave's `int` line back to the arbiter.

## Interface

Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0. Must be 4-byte aligned.
- `NUM_REGS`, 8: number of read/write control registers, 1..64.
- `WAIT_STATES`, 0: extra cycles inserted before the response, 0..15.

Ports:
- `wb_clk_i`, in, 1: bus clock.
- `wb_rst_n_i`, in, 1: asynchronous reset, active low.
- `wbs_cyc_i`, in, 1: cycle valid.
- `wbs_stb_i`, in, 1: strobe.
- `wbs_we_i`, in, 1: 1 = write.
- `wbs_sel_i`, in, 4: byte-lane enables; bit n covers `dat[8n+7:8n]`.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_dat_i`, in, 32: write data.
- `wbs_dat_o`, out, 32: read data.
- `wbs_ack_o`, out, 1: one-cycle completion pulse.
- `wbs_err_o`, out, 1: one-cycle error pulse.
- `wbs_int_o`, out, 1: level interrupt.
- `reg_o`, out, 32*NUM_REGS: flattened control registers. Register k is `reg_o[32k+31:32k]`.
- `irq_i`, in, 32: interrupt sources, level sensitive. Used only with `WBS_REGBANK_IRQ_EN`.

## Operation

- **Address decode:**
  - Word index is `idx = (wbs_adr_i - BASE_ADDR) >> 2`, using 32-bit unsigned arithmetic.
  - A request is in range if `wbs_adr_i >= BASE_ADDR`, `wbs_adr_i[1:0] == 0`, and `idx < NUM_REGS` (or `idx < NUM_REGS+2` when IRQ is enabled).
- **Register map:**
  - `idx` 0..NUM_REGS-1: read/write control registers.
  - `idx` NUM_REGS: IRQ_STATUS (only with `WBS_REGBANK_IRQ_EN`).
  - `idx` NUM_REGS+1: IRQ_MASK (only with `WBS_REGBANK_IRQ_EN`).
- **State machine:**
  - IDLE: on `cyc & stb`, latch `we`/`sel`/`adr`/`dat`, load the wait counter with WAIT_STATES, then go to WAIT. If WAIT_STATES == 0, go directly to RESP.
  - WAIT: decrement the counter; go to RESP when it reaches 1. If `cyc` or `stb` drops, go to IDLE with no response and no write.
  - RESP: hold for exactly one cycle. Assert `ack` (valid access) or `err` (out of range / misaligned), then go to IDLE.
- **Write commit:**
  - A write commits on the edge entering RESP, per enabled byte lane only. `sel = 0` is a legal no-op write and still acks.
  - Erroring writes modify nothing.
- **Read data:** `wbs_dat_o` holds the addressed register during RESP and is 0 in all other cycles, including on err.
- **No back-to-back capture:** RESP always returns to IDLE. A request still high in the cycle after RESP is treated as a new request.

## Timing

- **Reset values:** all `reg_o` = 0, `wbs_dat_o` = 0, `wbs_ack_o` = 0, `wbs_err_o` = 0, `wbs_int_o` = 0, IRQ_STATUS = 0, IRQ_MASK = 0. State is IDLE.
- **Response latency:** `ack`/`err` asserts 1 + WAIT_STATES cycles after the first edge sampling `cyc & stb` high. It is registered, lasts exactly one cycle, and `ack` and `err` are never high together.
- **`reg_o` update:** new values are visible in the same cycle as `ack`.
- **Reset mid-transaction:** asserting reset during WAIT or RESP forces all outputs to reset values immediately (asynchronously). No partial write survives.
- **Request inputs:** `wbs_we_i`, `wbs_sel_i`, `wbs_adr_i` and `wbs_dat_i` are sampled only in IDLE. Changes during WAIT are ignored.

## Configuration

`WBS_REGBANK_IRQ_EN`:

- **Defined:**
  - IRQ_STATUS bit n sets on any cycle where `irq_i[n]` = 1.
  - A write of 1 to a bit clears it (W1C, byte-lane gated). If set and clear hit the same bit in the same cycle, set wins.
  - IRQ_MASK is plain read/write.
  - `wbs_int_o` is registered `|(IRQ_STATUS & IRQ_MASK)`, one cycle after the status/mask change.
- **Not defined:**
  - `idx` NUM_REGS and NUM_REGS+1 return `err`.
  - `irq_i` is ignored.
  - `wbs_int_o` is tied to 0.

## Test plan

All scenarios use BASE_ADDR = 32'h0001_0000 and NUM_REGS = 8.

- **Write then read, no wait states:** WAIT_STATES = 0; write 32'hDEADBEEF to 0x0001_0008 with `sel` = 4'hF. Requires `ack` 1 cycle after `stb`, `reg_o[95:64]` = DEADBEEF, and a read of 0x0001_0008 returning DEADBEEF.
- **Byte-lane write with wait states:** WAIT_STATES = 3; write 32'h11223344 with `sel` = 4'b0101 over DEADBEEF. Requires `ack` exactly 4 cycles after `stb`, and register = 32'hDE22BE44.
- **Error cases:** reads of 0x0001_0020, 0x0000_FFFC and 0x0001_0002. Each requires a one-cycle `err`, no `ack`, `wbs_dat_o` = 0, and all registers unchanged.
- **Abort:** WAIT_STATES = 5; drop `cyc` 2 cycles into a write. Requires no `ack`/`err` and the register unchanged. The next request then completes normally.
- **IRQ, with `WBS_REGBANK_IRQ_EN`:**
  - Write IRQ_MASK = 0x1, then pulse `irq_i[0]` for 1 cycle. Requires IRQ_STATUS = 0x1 and `wbs_int_o` high.
  - W1C 0x1 to IRQ_STATUS while `irq_i[0]` is held high: the status stays 1.
  - Release `irq_i[0]` and W1C again: the status goes to 0 and `wbs_int_o` goes low one cycle later.
- **Async reset:** assert `wb_rst_n_i` low mid-WAIT. Requires all outputs to be 0 in the same cycle and all registers to read 0 afterwards.

Source files
------------

// File: rtl/wbs_regbank.sv
// rtl/wbs_regbank.sv - Wishbone slave control register bank with programmable wait states
// Define WBS_REGBANK_IRQ_EN to add the IRQ_STATUS (W1C) / IRQ_MASK pair driving wbs_int_o.
module wbs_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic                     wbs_int_o,
  output logic [32*NUM_REGS-1:0]   reg_o,
  input  logic [31:0]              irq_i
);
  localparam int IW = 7;
`ifdef WBS_REGBANK_IRQ_EN
  localparam int NUM_IDX = NUM_REGS + 2;
`else
  localparam int NUM_IDX = NUM_REGS;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, valid_q, ack_q, err_q;
  logic [3:0]    sel_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   dat_q;
  logic [31:0]   regs_q [NUM_REGS];

  logic          req, adr_valid, enter_resp, wr_en;
  logic          cur_we, cur_valid;
  logic [3:0]    cur_sel;
  logic [IW-1:0] cur_idx;
  logic [31:0]   cur_dat, off, rdata;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign off       = wbs_adr_i - BASE_ADDR;
  assign adr_valid = (wbs_adr_i >= BASE_ADDR) && (off[1:0] == 2'b00) &&
                     ({2'b00, off[31:2]} < 32'(NUM_IDX));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!req)              state_d = S_IDLE;
        else if (cnt_q == 4'd1) state_d = S_RESP;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the capture edge, so use live inputs in IDLE.
  always_comb begin
    enter_resp = (state_d == S_RESP);
    if (state_q == S_IDLE) begin
      cur_we    = wbs_we_i;
      cur_sel   = wbs_sel_i;
      cur_idx   = off[IW+1:2];
      cur_dat   = wbs_dat_i;
      cur_valid = adr_valid;
    end else begin
      cur_we    = we_q;
      cur_sel   = sel_q;
      cur_idx   = idx_q;
      cur_dat   = dat_q;
      cur_valid = valid_q;
    end
    wr_en = enter_resp & cur_valid & cur_we;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      dat_q   <= 32'd0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req) begin
        we_q    <= wbs_we_i;
        sel_q   <= wbs_sel_i;
        idx_q   <= off[IW+1:2];
        dat_q   <= wbs_dat_i;
        valid_q <= adr_valid;
      end
      ack_q <= enter_resp & cur_valid;
      err_q <= enter_resp & ~cur_valid;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 32'd0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (cur_idx == IW'(k))
          for (int b = 0; b < 4; b++)
            if (cur_sel[b]) regs_q[k][8*b +: 8] <= cur_dat[8*b +: 8];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_o
    assign reg_o[32*k +: 32] = regs_q[k];
  end

`ifdef WBS_REGBANK_IRQ_EN
  logic [31:0] status_q, status_d, mask_q, mask_d;
  logic        int_q;

  // Clear first, then OR in the sources so a same-cycle set beats the W1C.
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_en && cur_sel[b] && cur_idx == IW'(NUM_REGS))
        status_d[8*b +: 8] = status_q[8*b +: 8] & ~cur_dat[8*b +: 8];
      if (wr_en && cur_sel[b] && cur_idx == IW'(NUM_REGS + 1))
        mask_d[8*b +: 8] = cur_dat[8*b +: 8];
    end
    status_d = status_d | irq_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      status_q <= 32'd0;
      mask_q   <= 32'd0;
      int_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      int_q    <= |(status_q & mask_q);
    end
  end
  assign wbs_int_o = int_q;
`else
  logic unused_irq;
  assign unused_irq = ^irq_i;
  assign wbs_int_o  = 1'b0;
`endif

  always_comb begin
    rdata = 32'd0;
    for (int k = 0; k < NUM_REGS; k++)
      if (idx_q == IW'(k)) rdata = regs_q[k];
`ifdef WBS_REGBANK_IRQ_EN
    if (idx_q == IW'(NUM_REGS))     rdata = status_q;
    if (idx_q == IW'(NUM_REGS + 1)) rdata = mask_q;
`endif
  end

  assign wbs_dat_o = ack_q ? rdata : 32'd0;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
endmodule
